// File: rtl/ppm_pkg.sv
// -----------------------------------------------------------------------------
// ppm_pkg
// Shared definitions for the 4-PPM link (transmitter and receiver).
//   SYM_IDLE       code driven on sym_out when no data symbol is on the line
//   SYMS_PER_BYTE  2-bit symbols per byte
//   CHIPS_PER_SYM  chips (candidate pulse positions) per symbol slot
//   ppm_state_t    transmit engine states
// -----------------------------------------------------------------------------
package ppm_pkg;

    localparam logic [2:0] SYM_IDLE      = 3'b100;
    localparam int         SYMS_PER_BYTE = 4;
    localparam int         CHIPS_PER_SYM = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } ppm_state_t;

    // Symbol currently at the head of a byte being shifted out MSB pair first.
    function automatic logic [1:0] head_sym(input logic [7:0] shift);
        return shift[7:6];
    endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// -----------------------------------------------------------------------------
// ppm_slot_timer
// Divides clk16 into chips (OVS cycles each) and symbol slots (4 chips each).
// Counters hold at zero while the engine is not running, so the first cycle
// after run rises is always chip 0, oversample 0.
//   clk16     sole clock, rising edge
//   rst       asynchronous, active-high reset
//   run       engine is in SEND or GAP
//   chip      current chip within the slot, 0..3
//   slot_end  high in the last cycle of a slot (combinational)
// -----------------------------------------------------------------------------
module ppm_slot_timer
    import ppm_pkg::*;
#(
    parameter int  OVS   = 4,
    localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1
) (
    input  logic       clk16,
    input  logic       rst,
    input  logic       run,
    output logic [1:0] chip,
    output logic       slot_end
);

    localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);
    localparam logic [1:0]       CHIP_LAST = 2'(CHIPS_PER_SYM - 1);

    logic [OVS_W-1:0] ovs_cnt;
    logic             chip_end;

    assign chip_end = (ovs_cnt == OVS_LAST);
    assign slot_end = run && chip_end && (chip == CHIP_LAST);

    // NOTE: clocked state is always assigned with <= so every register samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            ovs_cnt <= '0;
            chip    <= '0;
        end else if (!run) begin
            ovs_cnt <= '0;
            chip    <= '0;
        end else if (chip_end) begin
            ovs_cnt <= '0;
            chip    <= chip + 2'd1;   // 3 -> 0 wraps at the slot end
        end else begin
            ovs_cnt <= ovs_cnt + OVS_W'(1);
        end
    end

endmodule

// File: rtl/ppm_encoder.sv
// -----------------------------------------------------------------------------
// ppm_encoder
// 4-PPM transmitter. Bytes arrive over valid/ready into a one-byte holding
// buffer, are moved into a shift register and sent as four 2-bit symbols,
// MSB pair first. Each symbol occupies one slot of 4 chips; the line is high
// for the whole chip whose index equals the symbol value. Optional idle gap
// slots follow every byte. All line/status outputs are registered and
// mutually aligned.
//   clk16       sole clock, rising edge
//   rst         asynchronous, active-high reset
//   Din         byte to transmit, sampled on handshake
//   din_valid   Din valid
//   din_ready   holding buffer empty (combinational)
//   ppm_out     PPM line
//   sym_out     current symbol 0..3, SYM_IDLE when nothing is on the line
//   sym_strobe  pulse in the last cycle of each data symbol slot
//   byte_done   pulse with the sym_strobe of the last symbol of a byte
//   busy        engine in SEND or GAP
// -----------------------------------------------------------------------------
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int OVS         = 4,
    parameter int GAP_SYMBOLS = 0
) (
    input  logic       clk16,
    input  logic       rst,
    input  logic [7:0] Din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ppm_out,
    output logic [2:0] sym_out,
    output logic       sym_strobe,
    output logic       byte_done,
    output logic       busy
);

    localparam logic [1:0] SYM_LAST = 2'(SYMS_PER_BYTE - 1);
    localparam logic [3:0] GAP_LAST = (GAP_SYMBOLS > 0) ? 4'(GAP_SYMBOLS - 1) : 4'd0;

    ppm_state_t state;
    logic       buf_full;
    logic [7:0] buf_byte;
    logic [7:0] shift;
    logic [1:0] sym_idx;
    logic [3:0] gap_cnt;

    logic       run;
    logic [1:0] chip;
    logic       slot_end;
    logic       in_fire;
    logic       byte_end;
    logic       gap_end;
    logic       frame_end;
    logic       reload;

    assign din_ready = ~buf_full;
    assign in_fire   = din_valid & ~buf_full;
    assign run       = (state == SEND) || (state == GAP);

    ppm_slot_timer #(.OVS(OVS)) u_timer (
        .clk16    (clk16),
        .rst      (rst),
        .run      (run),
        .chip     (chip),
        .slot_end (slot_end)
    );

    // A frame is a byte plus its trailing gap; the buffer is only drained when
    // a frame ends (or straight away from IDLE), which gives zero-bubble
    // back-to-back transmission.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        byte_end  = 1'b0;
        gap_end   = 1'b0;
        frame_end = 1'b0;
        reload    = 1'b0;
        case (state)
            IDLE: begin
                reload = buf_full;
            end
            SEND: begin
                byte_end  = slot_end && (sym_idx == SYM_LAST);
                frame_end = byte_end && (GAP_SYMBOLS == 0);
                reload    = frame_end && buf_full;
            end
            GAP: begin
                gap_end   = slot_end && (gap_cnt == GAP_LAST);
                frame_end = gap_end;
                reload    = frame_end && buf_full;
            end
            default: begin
                reload = 1'b0;
            end
        endcase
    end

    // NOTE: every register, including the data holding registers, is cleared
    // by reset so a reset mid-byte leaves no stale byte to be sent later.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            buf_byte   <= '0;
            shift      <= '0;
            sym_idx    <= '0;
            gap_cnt    <= '0;
            ppm_out    <= 1'b0;
            sym_out    <= SYM_IDLE;
            sym_strobe <= 1'b0;
            byte_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Holding buffer. A handshake needs buf_full=0 and a drain needs
            // buf_full=1, so the two cannot coincide on one edge.
            if (in_fire) begin
                buf_byte <= Din;
                buf_full <= 1'b1;
            end else if (reload) begin
                buf_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (reload) begin
                        shift   <= buf_byte;
                        sym_idx <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (slot_end) begin
                        shift   <= shift << 2;
                        sym_idx <= sym_idx + 2'd1;   // wraps to 0 after symbol 3
                        if (byte_end) begin
                            if (GAP_SYMBOLS > 0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else if (reload) begin
                                shift <= buf_byte;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    if (slot_end) begin
                        gap_cnt <= gap_cnt + 4'd1;
                        if (gap_end) begin
                            gap_cnt <= '0;
                            sym_idx <= '0;
                            if (reload) begin
                                shift <= buf_byte;
                                state <= SEND;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Registered line and status, all describing the same slot cycle.
            ppm_out    <= (state == SEND) && (chip == head_sym(shift));
            sym_out    <= (state == SEND) ? {1'b0, head_sym(shift)} : SYM_IDLE;
            sym_strobe <= (state == SEND) && slot_end;
            byte_done  <= byte_end;
            busy       <= run;
        end
    end

endmodule

// File: tb/tb_ppm_encoder.sv
// -----------------------------------------------------------------------------
// tb_ppm_encoder
// Three encoders with different parameters run side by side:
//   instance 0: OVS=4, GAP_SYMBOLS=0
//   instance 1: OVS=4, GAP_SYMBOLS=2
//   instance 2: OVS=2, GAP_SYMBOLS=0
// The reference model works on a per-byte schedule: a byte accepted on edge
// E0 is loaded on edge L = max(E0+1, previous L + frame length) and its line
// is a pure function of (cycle - L - 1). Every output of every instance is
// compared each falling edge.
// -----------------------------------------------------------------------------
module tb_ppm_encoder;
    import ppm_pkg::*;

    localparam int N = 3;

    logic       clk16 = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] din        [N];
    logic       din_valid  [N];
    logic       din_ready  [N];
    logic       ppm_out    [N];
    logic [2:0] sym_out    [N];
    logic       sym_strobe [N];
    logic       byte_done  [N];
    logic       busy       [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_mode = 1'b0;

    // Reference model state
    bit         m_full [N];
    int         m_e0   [N];
    logic [7:0] m_bufb [N];
    int         m_free [N];
    int         sl     [N][2];
    logic [7:0] sb     [N][2];
    bit         sv     [N][2];

    // Stimulus queues
    logic [7:0] txq   [N][256];
    int         tx_wr [N];
    int         tx_rd [N];

    always #5 clk16 = ~clk16;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ppm_encoder #(
            .OVS         ((g == 2) ? 2 : 4),
            .GAP_SYMBOLS ((g == 1) ? 2 : 0)
        ) u_dut (
            .clk16      (clk16),
            .rst        (rst),
            .Din        (din[g]),
            .din_valid  (din_valid[g]),
            .din_ready  (din_ready[g]),
            .ppm_out    (ppm_out[g]),
            .sym_out    (sym_out[g]),
            .sym_strobe (sym_strobe[g]),
            .byte_done  (byte_done[g]),
            .busy       (busy[g])
        );
    end

    function automatic int p_ovs(input int g);
        return (g == 2) ? 2 : 4;
    endfunction

    function automatic int p_gap(input int g);
        return (g == 1) ? 2 : 0;
    endfunction

    // Frame length in cycles: 4 data slots plus gap slots, 4*OVS cycles each.
    function automatic int p_dur(input int g);
        return (4 + p_gap(g)) * 4 * p_ovs(g);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear(input int g);
        m_full[g] = 1'b0;
        m_e0[g]   = 0;
        m_free[g] = 0;
        for (int i = 0; i < 2; i++) sv[g][i] = 1'b0;
    endtask

    task automatic push(input int g, input logic [7:0] b);
        txq[g][tx_wr[g] % 256] = b;
        tx_wr[g]++;
    endtask

    // Model update on each rising edge, using pre-edge model state.
    always @(posedge clk16) begin
        cyc++;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                model_clear(g);
            end else if (m_full[g] && cyc >= ((m_e0[g] + 1 > m_free[g]) ? m_e0[g] + 1 : m_free[g])) begin
                sl[g][1] = sl[g][0];
                sb[g][1] = sb[g][0];
                sv[g][1] = sv[g][0];
                sl[g][0] = cyc;
                sb[g][0] = m_bufb[g];
                sv[g][0] = 1'b1;
                m_free[g] = cyc + p_dur(g);
                m_full[g] = 1'b0;
            end else if (!m_full[g] && din_valid[g]) begin
                m_full[g] = 1'b1;
                m_e0[g]   = cyc;
                m_bufb[g] = din[g];
                if (tx_rd[g] != tx_wr[g]) tx_rd[g]++;
            end
        end
    end

    // Compare all outputs, then drive the next inputs, on each falling edge.
    always @(negedge clk16) begin
        for (int g = 0; g < N; g++) begin
            logic       e_ppm, e_stb, e_bd, e_busy;
            logic [2:0] e_sym;
            int         ovs, slot, t, s, b;
            e_ppm  = 1'b0;
            e_stb  = 1'b0;
            e_bd   = 1'b0;
            e_busy = 1'b0;
            e_sym  = SYM_IDLE;
            if (rst) begin
                model_clear(g);
                tx_rd[g] = tx_wr[g];
            end else begin
                ovs  = p_ovs(g);
                slot = 4 * ovs;
                for (int i = 0; i < 2; i++) begin
                    if (sv[g][i]) begin
                        t = cyc - sl[g][i] - 1;
                        if (t >= 0 && t < p_dur(g)) e_busy = 1'b1;
                        if (t >= 0 && t < 4 * slot) begin
                            s = t / slot;
                            b = int'(sb[g][i]);
                            e_sym = 3'((b >> (6 - 2 * s)) & 3);
                            e_ppm = (((t / ovs) % 4) == int'(e_sym));
                            e_stb = ((t % slot) == slot - 1);
                            e_bd  = (t == 4 * slot - 1);
                        end
                    end
                end
            end
            check($sformatf("i%0d c%0d ppm_out", g, cyc), 32'(ppm_out[g]), 32'(e_ppm));
            check($sformatf("i%0d c%0d sym_out", g, cyc), 32'(sym_out[g]), 32'(e_sym));
            check($sformatf("i%0d c%0d sym_strobe", g, cyc), 32'(sym_strobe[g]), 32'(e_stb));
            check($sformatf("i%0d c%0d byte_done", g, cyc), 32'(byte_done[g]), 32'(e_bd));
            check($sformatf("i%0d c%0d busy", g, cyc), 32'(busy[g]), 32'(e_busy));
            check($sformatf("i%0d c%0d din_ready", g, cyc), 32'(din_ready[g]), 32'(!m_full[g]));

            // Drive. While the buffer is full, Din carries garbage that must
            // never be accepted; during reset valid is held high.
            if (rst) begin
                din_valid[g] = 1'b1;
                din[g]       = 8'($urandom);
            end else if (m_full[g]) begin
                din_valid[g] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                din[g]       = 8'($urandom);
            end else if (tx_rd[g] != tx_wr[g] && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                din_valid[g] = 1'b1;
                din[g]       = txq[g][tx_rd[g] % 256];
            end else begin
                din_valid[g] = 1'b0;
                din[g]       = 8'($urandom);
            end
        end
    end

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk16);
            done = 1'b1;
            for (int g = 0; g < N; g++) begin
                if (tx_rd[g] != tx_wr[g] || m_full[g] || cyc <= m_free[g] + 1) done = 1'b0;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk16);
        #2 rst = 1'b1;
        #1;
        // Outputs must fall asynchronously, before any further clock edge.
        for (int g = 0; g < N; g++) begin
            check($sformatf("i%0d async_rst ppm_out", g), 32'(ppm_out[g]), 32'd0);
            check($sformatf("i%0d async_rst sym_out", g), 32'(sym_out[g]), 32'(SYM_IDLE));
            check($sformatf("i%0d async_rst busy", g), 32'(busy[g]), 32'd0);
            check($sformatf("i%0d async_rst din_ready", g), 32'(din_ready[g]), 32'd1);
        end
        repeat (3) @(posedge clk16);
        #2 rst = 1'b0;
    endtask

    initial begin
        bit hit;
        for (int g = 0; g < N; g++) begin
            din[g]       = '0;
            din_valid[g] = 1'b0;
            tx_wr[g]     = 0;
            tx_rd[g]     = 0;
            model_clear(g);
        end

        repeat (3) @(posedge clk16);
        #2 rst = 1'b0;

        // Single bytes, back-to-back pair through the gap instance.
        push(0, 8'h4B);
        push(1, 8'h3C);
        push(1, 8'hC3);
        push(2, 8'h1B);
        wait_drain(2000);

        // Back-to-back with valid held: 8'h00 then 8'hFF with no bubble.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(2, 8'h00);
        push(2, 8'hFF);
        wait_drain(2000);

        // Reset 30 cycles into a byte with a second byte buffered.
        push(0, 8'h96);
        push(0, 8'h5A);
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge clk16);
            if (sv[0][0] && cyc == sl[0][0] + 1 + 30) hit = 1'b1;
        end
        if (!hit) check("reset_point_timeout", 32'd0, 32'd1);
        pulse_reset();
        push(0, 8'hA5);
        push(2, 8'hA5);
        wait_drain(2000);

        // Randomized traffic with idle gaps and random valid while stalled.
        rand_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int g = 0; g < N; g++) push(g, 8'($urandom));
        end
        wait_drain(8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
